// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the SRAM wrappers:
// loader FSM states, the idle strobe pattern and the SRAM address width.
package prog_loader_pkg;

  localparam int ADDR_W = 18;

  // {EN, OE, WE}, all active-low, so all-ones is a deselected chip
  localparam logic [2:0] SRAM_IDLE = 3'b111;

  typedef enum logic [3:0] {
    HDR_LO,
    HDR_HI,
    W_LO,
    W_HI,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_PULSE,
    RD_CHECK,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/prog_loader_byte_pack16.sv
// Two-byte little-endian packer: first push fills [7:0], second fills [15:8]
// and raises valid; the word holds until the next low byte arrives.
module byte_pack16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o,
  output logic        valid_o
);

  logic        half_q;
  logic [15:0] word_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q  <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (push_i) begin
      if (!half_q) begin
        word_q[7:0] <= byte_i;
        half_q      <= 1'b1;
        valid_q     <= 1'b0;
      end else begin
        word_q[15:8] <= byte_i;
        half_q       <= 1'b0;
        valid_q      <= 1'b1;
      end
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: takes a length-prefixed byte image, writes it word by word into
// Ram2 with EN/OE/WE strobes, optionally verifies each word, then releases the CPU.
// Handshake: a byte moves on any rising edge where rx_valid && rx_ready are both high;
// the source must hold rx_data stable until that edge.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       WE_CYCLES = 2,
  parameter int unsigned       RD_CYCLES = 2,
  parameter bit                VERIFY    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] Ram2Addr,
  inout  wire  [15:0]       Ram2Data,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic              Ram2EN,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       words,
  output ld_state_e         state_o
);

  localparam int CNT_W = 8;

  ld_state_e         state_q;
  logic              rx_ready_q, en_q, oe_q, we_q, drive_q;
  logic              cpu_hold_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q, err_addr_q;
  logic [15:0]       words_q, idx_q, n_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic        xfer;
  logic        pack_push;
  logic [15:0] pack_word;
  logic        pack_valid;

  assign xfer      = rx_valid && rx_ready_q;
  assign pack_push = xfer && ((state_q == W_LO) || (state_q == W_HI));

  byte_pack16 u_pack (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (pack_push),
    .byte_i  (rx_data),
    .word_o  (pack_word),
    .valid_o (pack_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= HDR_LO;
      rx_ready_q           <= 1'b0;
      addr_q               <= '0;
      {en_q, oe_q, we_q}   <= SRAM_IDLE;
      drive_q              <= 1'b0;
      cpu_hold_q           <= 1'b1;
      done_q               <= 1'b0;
      err_q                <= 1'b0;
      err_addr_q           <= '0;
      words_q              <= '0;
      idx_q                <= '0;
      n_q                  <= '0;
      rd_q                 <= '0;
      cnt_q                <= '0;
    end else begin
      case (state_q)
        HDR_LO: begin
          rx_ready_q <= 1'b1;
          if (xfer) begin
            n_q[7:0] <= rx_data;
            state_q  <= HDR_HI;
          end
        end
        HDR_HI: if (xfer) begin
          n_q[15:8] <= rx_data;
          if ({rx_data, n_q[7:0]} == 16'd0) begin
            state_q    <= DONE;
            rx_ready_q <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q <= W_LO;
          end
        end
        W_LO: if (xfer) state_q <= W_HI;
        // Address and bus drive are set here so they are already stable in WR_SETUP
        W_HI: if (xfer) begin
          state_q    <= WR_SETUP;
          rx_ready_q <= 1'b0;
          addr_q     <= BASE_ADDR + ADDR_W'(idx_q);
          en_q       <= 1'b0;
          drive_q    <= 1'b1;
        end
        WR_SETUP: if (pack_valid) begin
          state_q <= WR_PULSE;
          we_q    <= 1'b0;
          cnt_q   <= CNT_W'(WE_CYCLES - 1);
        end
        WR_PULSE: begin
          if (cnt_q == '0) begin
            we_q    <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WR_HOLD: begin
          drive_q <= 1'b0;
          if (VERIFY) begin
            oe_q    <= 1'b0;
            cnt_q   <= CNT_W'(RD_CYCLES - 1);
            state_q <= RD_PULSE;
          end else begin
            state_q <= RD_CHECK;
          end
        end
        RD_PULSE: begin
          if (cnt_q == '0) begin
            rd_q    <= Ram2Data;
            oe_q    <= 1'b1;
            state_q <= RD_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RD_CHECK: begin
          en_q <= 1'b1;
          if (VERIFY && (rd_q != pack_word)) begin
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
            state_q    <= ERR;
          end else begin
            words_q <= words_q + 16'd1;
            idx_q   <= idx_q + 16'd1;
            if ((words_q + 16'd1) == n_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q    <= W_LO;
              rx_ready_q <= 1'b1;
            end
          end
        end
        default: ;  // DONE and ERR are terminal until rst
      endcase
    end
  end

  assign Ram2Data = drive_q ? pack_word : 16'bz;

  assign rx_ready = rx_ready_q;
  assign Ram2Addr = addr_q;
  assign Ram2OE   = oe_q;
  assign Ram2WE   = we_q;
  assign Ram2EN   = en_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign words    = words_q;
  assign state_o  = state_q;

endmodule
